// File: rtl/text_buffer_pkg.sv
// Shared types and constants for the character text buffer.
// The SCROLL state exists only when TEXT_BUFFER_SCROLL_EN is defined.
package text_buffer_pkg;

    localparam logic [8:0] FILL_DEFAULT = 9'h120;

`ifdef TEXT_BUFFER_SCROLL_EN
    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        CLEAR
    } state_t;
`endif

endpackage

// File: rtl/text_buffer_ram.sv
// Character cell storage: one write port, one registered display read port and,
// with TEXT_BUFFER_SCROLL_EN, a combinational internal read port for scrolling.
module text_buffer_ram #(
    parameter int          DEPTH  = 64,
    parameter int          AW     = 6,
    parameter int          DATA_W = 9,
    parameter logic [DATA_W-1:0] FILL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     rd_addr,
`ifdef TEXT_BUFFER_SCROLL_EN
    input  logic [AW-1:0]     ird_addr,
    output logic [DATA_W-1:0] ird_data,
`endif
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking write above means a same-cycle read sees the old cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= FILL;
        end else if ({1'b0, rd_addr} >= (AW+1)'(DEPTH)) begin
            rd_data <= FILL;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

`ifdef TEXT_BUFFER_SCROLL_EN
    assign ird_data = mem[ird_addr];
`endif

endmodule

// File: rtl/text_buffer.sv
// Text-mode character buffer with cursor, backspace and clear sequencer.
// Define TEXT_BUFFER_SCROLL_EN to scroll up one row instead of wrapping.
module text_buffer
    import text_buffer_pkg::*;
#(
    parameter int COLS   = 16,
    parameter int ROWS   = 4,
    parameter int DATA_W = 9,
    parameter logic [DATA_W-1:0] FILL = DATA_W'(FILL_DEFAULT),
    localparam int DEPTH = COLS * ROWS,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              bs,
    input  logic              clr,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW-1:0]     cursor,
    output logic              busy
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t            state;
    logic [AW-1:0]     addr;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic [AW-1:0]     bs_addr;

`ifdef TEXT_BUFFER_SCROLL_EN
    logic [AW-1:0]     ird_addr;
    logic [DATA_W-1:0] ird_data;
    assign ird_addr = addr + AW'(COLS);
`endif

    assign bs_addr = (cursor == '0) ? '0 : cursor - 1'b1;
    assign busy    = (state != IDLE);

    always_comb begin
        we    = 1'b0;
        waddr = addr;
        wdata = FILL;
        unique case (state)
            IDLE: begin
                if (clr) begin
                    we = 1'b0;
                end else if (wr_en) begin
                    we    = 1'b1;
                    waddr = cursor;
                    wdata = wr_data;
                end else if (bs) begin
                    we    = 1'b1;
                    waddr = bs_addr;
                end
            end
            CLEAR: begin
                we = 1'b1;
            end
`ifdef TEXT_BUFFER_SCROLL_EN
            SCROLL: begin
                we = 1'b1;
                if (addr < AW'(DEPTH - COLS)) begin
                    wdata = ird_data;
                end
            end
`endif
            default: we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            addr   <= '0;
            cursor <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr) begin
                        state  <= CLEAR;
                        addr   <= '0;
                        cursor <= '0;
                    end else if (wr_en) begin
                        if (cursor == LAST) begin
`ifdef TEXT_BUFFER_SCROLL_EN
                            state <= SCROLL;
                            addr  <= '0;
`else
                            cursor <= '0;
`endif
                        end else begin
                            cursor <= cursor + 1'b1;
                        end
                    end else if (bs) begin
                        cursor <= bs_addr;
                    end
                end
                CLEAR: begin
                    if (addr == LAST) begin
                        state <= IDLE;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
`ifdef TEXT_BUFFER_SCROLL_EN
                SCROLL: begin
                    if (addr == LAST) begin
                        state  <= IDLE;
                        cursor <= AW'(DEPTH - COLS);
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    text_buffer_ram #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (DATA_W),
        .FILL   (FILL)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .rd_addr  (rd_addr),
`ifdef TEXT_BUFFER_SCROLL_EN
        .ird_addr (ird_addr),
        .ird_data (ird_data),
`endif
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer (COLS=4, ROWS=2): directed steps plus random traffic
// checked against a whole-screen reference model.
module tb_text_buffer;

    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = 3;
    localparam logic [8:0] FILL = 9'h120;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [8:0]    wr_data = '0;
    logic          bs = 1'b0;
    logic          clr = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [8:0]    rd_data;
    logic [AW-1:0] cursor;
    logic          busy;

    text_buffer #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .DATA_W (9),
        .FILL   (FILL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .bs      (bs),
        .clr     (clr),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .cursor  (cursor),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    logic [8:0] mem [DEPTH];
    int m_cur    = 0;
    int m_busy   = 0;
    bit m_scroll = 0;
    int total    = 0;
    int passed   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // One clock: apply inputs, advance the model at the edge, check at negedge.
    task automatic step(input bit r, input bit w, input bit b, input bit c,
                        input logic [8:0] d, input int ra);
        logic [8:0] rexp;
        bit         rvalid;
        rst = r; wr_en = w; bs = b; clr = c;
        wr_data = d; rd_addr = AW'(ra);
        @(posedge clk);
        rvalid = (m_busy == 0);
        rexp   = mem[ra];
        if (r) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = FILL;
            m_busy = DEPTH; m_cur = 0; m_scroll = 0;
            rvalid = 1; rexp = FILL;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0 && m_scroll) begin
                m_cur = DEPTH - COLS;
                m_scroll = 0;
            end
        end else if (c) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = FILL;
            m_busy = DEPTH; m_cur = 0;
        end else if (w) begin
            mem[m_cur] = d;
            if (m_cur == DEPTH - 1) begin
`ifdef TEXT_BUFFER_SCROLL_EN
                for (int i = 0; i < DEPTH; i++)
                    mem[i] = (i < DEPTH - COLS) ? mem[i + COLS] : FILL;
                m_busy = DEPTH; m_scroll = 1;
`else
                m_cur = 0;
`endif
            end else begin
                m_cur++;
            end
        end else if (b) begin
            if (m_cur > 0) m_cur--;
            mem[m_cur] = FILL;
        end
        @(negedge clk);
        chk("busy", 32'(busy), 32'(m_busy > 0));
        chk("cursor", 32'(cursor), 32'(m_cur));
        if (rvalid) chk("rd_data", 32'(rd_data), 32'(rexp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, '0, i);
    endtask

    initial begin
        int p;
        step(1, 0, 0, 0, '0, 0);
        step(1, 0, 0, 0, '0, 0);
        chk("reset_rd_fill", 32'(rd_data), 32'(FILL));
        idle(DEPTH);
        chk("reset_busy_done", 32'(busy), 32'd0);
        read_all();

        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 9'h041, 0);
        chk("three_writes_cursor", 32'(cursor), 32'd3);
        step(0, 0, 0, 0, '0, 1);
        chk("read_cell1", 32'(rd_data), 32'h041);

        step(0, 0, 1, 0, '0, 0);
        chk("bs_cursor", 32'(cursor), 32'd2);
        step(0, 0, 0, 0, '0, 2);
        chk("bs_cell2", 32'(rd_data), 32'(FILL));
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0, 0);
        chk("bs_at_zero_cursor", 32'(cursor), 32'd0);
        step(0, 0, 0, 0, '0, 0);
        chk("bs_at_zero_cell0", 32'(rd_data), 32'(FILL));

        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 9'(9'h0a0 + i), 0);
        step(0, 1, 0, 1, 9'h055, 0);
        chk("clr_wr_busy", 32'(busy), 32'd1);
        idle(DEPTH);
        chk("clr_cursor", 32'(cursor), 32'd0);
        read_all();

        for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, 0, 9'(i), 0);
`ifdef TEXT_BUFFER_SCROLL_EN
        chk("scroll_busy", 32'(busy), 32'd1);
        idle(DEPTH);
        chk("scroll_cursor", 32'(cursor), 32'd4);
        step(0, 0, 0, 0, '0, 0);
        chk("scroll_cell0", 32'(rd_data), 32'h005);
`else
        chk("wrap_cursor", 32'(cursor), 32'd0);
        step(0, 0, 0, 0, '0, 7);
        chk("wrap_cell7", 32'(rd_data), 32'h008);
`endif
        read_all();

        step(0, 0, 0, 1, '0, 0);
        idle(2);
        step(1, 0, 0, 0, '0, 0);
        chk("rst_mid_clear_busy", 32'(busy), 32'd1);
        idle(DEPTH);
        chk("rst_mid_clear_done", 32'(busy), 32'd0);
        read_all();

        for (int n = 0; n < 400; n++) begin
            p = int'($urandom_range(0, 199));
            step(p == 199, p < 140, p >= 170, p < 4,
                 9'($urandom), int'($urandom_range(0, DEPTH - 1)));
        end
        idle(DEPTH);
        read_all();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/text_buffer.md
TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 Parameter COLS, default 16, characters per row.
REQ-002 Parameter ROWS, default 4, number of rows; DEPTH = COLS*ROWS, AW = $clog2(DEPTH).
REQ-003 Parameter DATA_W, default 9, bits per character cell (code plus attribute).
REQ-004 Parameter FILL, default 9'h120, blank-cell value written on clear, backspace and scroll.
REQ-005 clk  input  1  clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr_en  input  1  write wr_data at the cursor, then advance the cursor.
REQ-008 wr_data  input  DATA_W  character to write.
REQ-009 bs  input  1  backspace: move the cursor back and blank the new cell.
REQ-010 clr  input  1  clear the screen and home the cursor.
REQ-011 rd_addr  input  AW  display-side read address.
REQ-012 rd_data  output  DATA_W  registered display-side read data.
REQ-013 cursor  output  AW  current write position.
REQ-014 busy  output  1  high while a clear or scroll sequence runs.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR and, when the macro is defined, SCROLL; busy = (state != IDLE).
REQ-016 CLEAR SHALL write FILL to address 0..DEPTH-1, one cell per cycle, then return to IDLE, so busy lasts exactly DEPTH cycles.
REQ-017 In IDLE, command priority SHALL be clr > wr_en > bs; lower-priority commands in the same cycle are dropped.
REQ-018 clr in IDLE SHALL enter CLEAR on the next cycle and set cursor to 0.
REQ-019 wr_en in IDLE SHALL write the cell at cursor and increment cursor; at DEPTH-1 without the macro, cursor SHALL wrap to 0.
REQ-020 bs in IDLE SHALL set cursor to cursor-1 and write FILL there; at cursor 0, cursor SHALL stay 0 and cell 0 SHALL become FILL.
REQ-021 wr_en, bs and clr asserted while busy SHALL be ignored, with no queuing.
REQ-022 rd_data SHALL equal cell[rd_addr] sampled one cycle earlier, giving 1-cycle latency.
REQ-023 During CLEAR or SCROLL, rd_data SHALL return either the old or the new contents of a cell, never X.
REQ-024 rd_addr >= DEPTH SHALL return FILL.
REQ-025 A write and a read of the same address in the same cycle SHALL return the old data (read-before-write).

Reset
REQ-026 rst SHALL force state CLEAR at address 0, cursor 0, rd_data FILL and busy 1, even in the middle of a sequence (the sequence restarts).
REQ-027 After rst deasserts, busy SHALL stay high for exactly DEPTH cycles.

Configuration
REQ-028 Macro TEXT_BUFFER_SCROLL_EN: when defined, wr_en at cursor DEPTH-1 SHALL write the cell and then enter SCROLL.
REQ-029 SCROLL SHALL copy cell[i+COLS] to cell[i] for i = 0..DEPTH-COLS-1 at one cell per cycle, write FILL to the last row, and then set cursor to DEPTH-COLS; busy lasts DEPTH cycles.
REQ-030 When TEXT_BUFFER_SCROLL_EN is undefined, no SCROLL state or internal read port SHALL exist, and the cursor wraps as in REQ-019.

Structure
REQ-031 Package text_buffer_pkg SHALL hold the state enum type and the default FILL constant.
REQ-032 Sub-module text_buffer_ram SHALL provide the storage: one write port, one registered display read port, and one combinational internal read port used only for scroll.

Verification (COLS=4, ROWS=2, DEPTH=8)
REQ-033 Reset: release rst -> busy high exactly 8 cycles; reading addresses 0..7 then returns 0x120.
REQ-034 Write 0x041 three times -> cursor 3; rd_addr=1 gives rd_data 0x041 one cycle later.
REQ-035 Eight writes 0x001..0x008 -> without the macro, cursor 0; with the macro, busy for 8 cycles, cells 0-3 = 0x005..0x008, cells 4-7 = 0x120, cursor 4.
REQ-036 bs at cursor 3 -> cursor 2, cell 2 = 0x120; bs at cursor 0 -> cursor 0, cell 0 = 0x120.
REQ-037 clr and wr_en in the same cycle -> write dropped, busy 8 cycles, cursor 0, all cells 0x120.
REQ-038 rst on the 3rd cycle of CLEAR -> clear restarts at address 0 and busy stays high for 8 cycles after rst releases.
